// File: rtl/dino_motion_core.sv
// Pixel-clock divider, button-driven saturating position offsets and run-animation frame select.
// Optional DINO_ANIM_FREEZE_EN: hold the animation counter and sprite while halt is high.
module dino_motion_core #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned STEP_DIV   = 100000,
   parameter int unsigned ANIM_DIV   = 2500000,
   parameter int unsigned MAX_OFFSET = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       halt,
   input  logic       leftbtn,
   input  logic       rightbtn,
   input  logic       upbtn,
   input  logic       downbtn,
   output logic       divided_clk,
   output logic       pix_en,
   output logic [9:0] leftaddr,
   output logic [9:0] rightaddr,
   output logic [9:0] upaddr,
   output logic [9:0] downaddr,
   output logic       sprite
);

   localparam int unsigned OFF_W  = 10;
   localparam int unsigned N_DIR  = 4;
   localparam int unsigned DIV_W  = (CLK_DIV  > 2) ? $clog2(CLK_DIV)  : 1;
   localparam int unsigned STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned ANIM_W = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;

   logic [DIV_W-1:0]              div_cnt_q, div_cnt_d;
   logic                          divided_clk_q, divided_clk_d;
   logic                          pix_en_q, pix_en_d;
   logic [STEP_W-1:0]             step_cnt_q, step_cnt_d;
   logic [ANIM_W-1:0]             anim_cnt_q, anim_cnt_d;
   logic                          sprite_q, sprite_d;
   logic [N_DIR-1:0]              sync1_q, sync1_d;
   logic [N_DIR-1:0]              sync2_q, sync2_d;
   logic [N_DIR-1:0][OFF_W-1:0]   off_q, off_d;
   logic                          step_tick_c;
   logic                          anim_run_c;
   logic                          anim_wrap_c;

   // Next-state logic; divider outputs are registered from the next count so they align with div_cnt_q
   always_comb begin
      div_cnt_d     = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
      divided_clk_d = (div_cnt_d >= DIV_W'(CLK_DIV / 2));
      pix_en_d      = (div_cnt_d == DIV_W'(CLK_DIV - 1));

      step_tick_c = pix_en_q && (step_cnt_q == STEP_W'(STEP_DIV - 1));
      step_cnt_d  = step_cnt_q;
      if (pix_en_q) begin
         step_cnt_d = (step_cnt_q == STEP_W'(STEP_DIV - 1)) ? '0 : step_cnt_q + STEP_W'(1);
      end

      sync1_d = {downbtn, upbtn, rightbtn, leftbtn};
      sync2_d = sync1_q;

      // Each direction climbs independently and saturates; halt freezes all of them
      off_d = off_q;
      for (int unsigned i = 0; i < N_DIR; i++) begin
         if (step_tick_c && !halt && sync2_q[i] && (off_q[i] < OFF_W'(MAX_OFFSET))) begin
            off_d[i] = off_q[i] + OFF_W'(1);
         end
      end

`ifdef DINO_ANIM_FREEZE_EN
      anim_run_c = pix_en_q && !halt;
`else
      anim_run_c = pix_en_q;
`endif
      anim_wrap_c = anim_run_c && (anim_cnt_q == ANIM_W'(ANIM_DIV - 1));
      anim_cnt_d  = anim_cnt_q;
      if (anim_run_c) begin
         anim_cnt_d = anim_wrap_c ? '0 : anim_cnt_q + ANIM_W'(1);
      end
      sprite_d = sprite_q ^ anim_wrap_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q     <= '0;
         divided_clk_q <= 1'b0;
         pix_en_q      <= 1'b0;
         step_cnt_q    <= '0;
         anim_cnt_q    <= '0;
         sprite_q      <= 1'b1;
         sync1_q       <= '0;
         sync2_q       <= '0;
         off_q         <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         divided_clk_q <= divided_clk_d;
         pix_en_q      <= pix_en_d;
         step_cnt_q    <= step_cnt_d;
         anim_cnt_q    <= anim_cnt_d;
         sprite_q      <= sprite_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         off_q         <= off_d;
      end
   end

   assign divided_clk = divided_clk_q;
   assign pix_en      = pix_en_q;
   assign leftaddr    = off_q[0];
   assign rightaddr   = off_q[1];
   assign upaddr      = off_q[2];
   assign downaddr    = off_q[3];
   assign sprite      = sprite_q;

endmodule

// File: tb/tb_dino_motion_core.sv
// Directed bench for dino_motion_core with a cycle-indexed reference model feeding an expectation queue.
module tb_dino_motion_core;

   typedef struct packed {
      logic             dclk;
      logic             pix;
      logic             spr;
      logic [3:0][9:0]  off;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       halt;
   logic       leftbtn, rightbtn, upbtn, downbtn;
   logic       divided_clk, pix_en, sprite;
   logic [9:0] leftaddr, rightaddr, upaddr, downaddr;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb_q[$];

   // Model state: cycles since reset, pixel ticks counted for animation, synchronizer and offsets
   int unsigned m_n = 0;
   int unsigned m_p = 0;
   logic [3:0]  m_s1 = '0;
   logic [3:0]  m_s2 = '0;
   int          m_off[4] = '{0, 0, 0, 0};

   dino_motion_core #(
      .CLK_DIV    (4),
      .STEP_DIV   (2),
      .ANIM_DIV   (3),
      .MAX_OFFSET (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .leftbtn     (leftbtn),
      .rightbtn    (rightbtn),
      .upbtn       (upbtn),
      .downbtn     (downbtn),
      .divided_clk (divided_clk),
      .pix_en      (pix_en),
      .leftaddr    (leftaddr),
      .rightaddr   (rightaddr),
      .upaddr      (upaddr),
      .downaddr    (downaddr),
      .sprite      (sprite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Steps at n%8==7 are step ticks; pixel ticks at n%4==3
   task automatic model_edge();
      logic [3:0] btn_in;
      btn_in = {downbtn, upbtn, rightbtn, leftbtn};
      if (reset) begin
         m_n = 0;
         m_p = 0;
         m_s1 = '0;
         m_s2 = '0;
         for (int i = 0; i < 4; i++) m_off[i] = 0;
      end else begin
         if ((m_n % 8) == 7 && !halt) begin
            for (int i = 0; i < 4; i++) begin
               if (m_s2[i] && m_off[i] < 5) m_off[i] = m_off[i] + 1;
            end
         end
`ifdef DINO_ANIM_FREEZE_EN
         if ((m_n % 4) == 3 && !halt) m_p++;
`else
         if ((m_n % 4) == 3) m_p++;
`endif
         m_s2 = m_s1;
         m_s1 = btn_in;
         m_n++;
      end
   endtask

   task automatic run(input int k);
      exp_t e;
      exp_t got;
      for (int c = 0; c < k; c++) begin
         @(posedge clk);
         model_edge();
         e.dclk = ((m_n % 4) >= 2);
         e.pix  = ((m_n % 4) == 3);
         e.spr  = (((m_p / 3) % 2) == 0);
         for (int i = 0; i < 4; i++) e.off[i] = 10'(m_off[i]);
         sb_q.push_back(e);
         #1;
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
         end else begin
            got = sb_q.pop_front();
            chk("divided_clk", 32'(divided_clk), 32'(got.dclk));
            chk("pix_en",      32'(pix_en),      32'(got.pix));
            chk("sprite",      32'(sprite),      32'(got.spr));
            chk("leftaddr",    32'(leftaddr),    32'(got.off[0]));
            chk("rightaddr",   32'(rightaddr),   32'(got.off[1]));
            chk("upaddr",      32'(upaddr),      32'(got.off[2]));
            chk("downaddr",    32'(downaddr),    32'(got.off[3]));
         end
      end
   endtask

   initial begin
      int k;
      logic spr_hold;
      reset = 1'b1; halt = 1'b0;
      leftbtn = 1'b0; rightbtn = 1'b0; upbtn = 1'b0; downbtn = 1'b0;

      // Reset and free-running divider
      run(3);
      chk("reset_sprite", 32'(sprite), 32'd1);
      chk("reset_pix",    32'(pix_en), 32'd0);
      reset = 1'b0;
      run(16);

      // Left held: climbs to 5 and saturates
      leftbtn = 1'b1;
      run(64);
      chk("left_sat",   32'(leftaddr),  32'd5);
      chk("right_idle", 32'(rightaddr), 32'd0);
      leftbtn = 1'b0;

      // Up+down held, halt at 2, then resume
      upbtn = 1'b1; downbtn = 1'b1;
      k = 0;
      while (m_off[2] != 2 && k < 64) begin run(1); k++; end
      chk("wait_up2", 32'(k < 64), 32'd1);
      halt = 1'b1;
      run(30);
      chk("halt_up",   32'(upaddr),   32'd2);
      chk("halt_down", 32'(downaddr), 32'd2);
      halt = 1'b0;
      run(24);
      chk("resume_up", 32'(upaddr), 32'd5);
      upbtn = 1'b0; downbtn = 1'b0;

      // Reset pulse mid-run while right is at 4
      rightbtn = 1'b1;
      k = 0;
      while (m_off[1] != 4 && k < 64) begin run(1); k++; end
      chk("wait_right4", 32'(k < 64), 32'd1);
      reset = 1'b1;
      run(1);
      chk("rst_right",  32'(rightaddr), 32'd0);
      chk("rst_left",   32'(leftaddr),  32'd0);
      chk("rst_sprite", 32'(sprite),    32'd1);
      chk("rst_dclk",   32'(divided_clk), 32'd0);
      reset = 1'b0; rightbtn = 1'b0;
      run(16);

      // Free-running animation
      run(30);
`ifdef DINO_ANIM_FREEZE_EN
      halt = 1'b1;
      run(1);
      spr_hold = sprite;
      for (int c = 0; c < 100; c++) begin
         run(1);
         chk("freeze_sprite", 32'(sprite), 32'(spr_hold));
      end
      halt = 1'b0;
      run(12);
`else
      spr_hold = sprite;
      run(12);
      chk("sprite_toggle12", 32'(sprite), 32'(!spr_hold));
`endif

      // Single-clock left glitch away from a step tick
      k = 0;
      while ((m_n % 8) != 1 && k < 16) begin run(1); k++; end
      chk("wait_phase", 32'(k < 16), 32'd1);
      leftbtn = 1'b1;
      run(1);
      leftbtn = 1'b0;
      run(16);
      chk("glitch_left", 32'(leftaddr), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
